// File: rtl/pattern_pkg.sv
// pattern_pkg: shared definitions for the pattern feeder slice.
//   - lane bit constants (bit0 red / lane 0 ... bit3 yellow / lane 3)
//   - song ROM entry layout: [4] END marker, [3:0] lanes
//   - feeder FSM state encoding
//   - LFSR tap mask and single-step helper
package pattern_pkg;

   localparam int ROM_W   = 5;
   localparam int END_BIT = 4;

   localparam logic [3:0] LANE0_RED    = 4'b0001;
   localparam logic [3:0] LANE1        = 4'b0010;
   localparam logic [3:0] LANE2        = 4'b0100;
   localparam logic [3:0] LANE3_YELLOW = 4'b1000;
   localparam logic [3:0] REST         = 4'b0000;

   // Fibonacci taps 16,14,13,11 expressed on bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // One left shift of the LFSR; the feedback bit enters at bit 0.
   function automatic logic [15:0] lfsr_step(input logic [15:0] value);
      return {value[14:0], ^(value & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pattern_feeder_if.sv
// pattern_feeder_if: bundle between the pattern feeder and its consumer.
//   start, advance, random_mode, loop : consumer -> feeder
//   command_out, valid, song_done,
//   song_index, notes_played          : feeder -> consumer
//   master modport = consumer side, slave modport = feeder side.
interface pattern_feeder_if #(
   parameter int ADDR_W = 8
);
   logic              start;
   logic              advance;
   logic              random_mode;
   logic              loop;
   logic [3:0]        command_out;
   logic              valid;
   logic              song_done;
   logic [ADDR_W-1:0] song_index;
   logic [15:0]       notes_played;

   modport master (
      output start, advance, random_mode, loop,
      input  command_out, valid, song_done, song_index, notes_played
   );

   modport slave (
      input  start, advance, random_mode, loop,
      output command_out, valid, song_done, song_index, notes_played
   );
endinterface

// File: rtl/song_rom.sv
// song_rom: synchronous single-port song ROM, one cycle read latency.
//   clk  : clock
//   addr : entry address (2^ADDR_W entries)
//   data : entry read at the previous clock edge, [4] END, [3:0] lanes
// Contents come from the INIT parameter (entry i at bits [i*ROM_W +: ROM_W]),
// so the table is fixed at elaboration without any load-time code.
module song_rom
   import pattern_pkg::*;
#(
   parameter int                            ADDR_W = 8,
   parameter logic [(2**ADDR_W)*ROM_W-1:0]  INIT   = '0
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr,
   output logic [ROM_W-1:0]  data
);

   // Registered read port.
   always_ff @(posedge clk) begin
      data <= INIT[int'(addr)*ROM_W +: ROM_W];
   end

endmodule

// File: rtl/pattern_feeder.sv
// pattern_feeder: offers the next 4-lane pattern to the falling-note stage.
//   CLOCK_25 : 25 MHz pixel clock
//   reset    : asynchronous active-high reset
//   bus      : slave side of pattern_feeder_if
//              start       restart song at index 0 (latches random_mode/loop)
//              advance     consumer request, rising edge consumed
//              command_out pattern on offer, valid when a real pattern
//              song_done   end of a non-looping song reached
//              song_index  ROM index of the pattern on command_out
//              notes_played accepted advances since start, saturating
// Patterns come from song_rom or from a 16-bit LFSR (LFSR_SEED must be nonzero).
module pattern_feeder
   import pattern_pkg::*;
#(
   parameter int                            ADDR_W    = 8,
   parameter logic [15:0]                   LFSR_SEED = 16'hACE1,
   parameter logic [(2**ADDR_W)*ROM_W-1:0]  ROM_INIT  = '0
) (
   input  logic             CLOCK_25,
   input  logic             reset,
   pattern_feeder_if.slave  bus
);

   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t            state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [15:0]       lfsr_q,    lfsr_d;
   logic [3:0]        cmd_q,     cmd_d;
   logic              valid_q,   valid_d;
   logic              done_q,    done_d;
   logic [ADDR_W-1:0] index_q,   index_d;
   logic [15:0]       notes_q,   notes_d;
   logic              advance_q, advance_d;
   logic              random_q,  random_d;
   logic              loop_q,    loop_d;
   logic              wrap_q,    wrap_d;

   logic              adv_edge_s;
   logic [15:0]       lfsr_next_s;
   logic [ROM_W-1:0]  rom_data_s;

   // The ROM is addressed with the next address so its data is ready in LOAD.
   song_rom #(
      .ADDR_W (ADDR_W),
      .INIT   (ROM_INIT)
   ) u_rom (
      .clk  (CLOCK_25),
      .addr (addr_d),
      .data (rom_data_s)
   );

   assign adv_edge_s  = bus.advance & ~advance_q;
   assign lfsr_next_s = lfsr_step(lfsr_q);

   // Next-state and output computation for the feeder FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      lfsr_d    = lfsr_q;
      cmd_d     = cmd_q;
      valid_d   = valid_q;
      done_d    = done_q;
      index_d   = index_q;
      notes_d   = notes_q;
      advance_d = bus.advance;
      random_d  = random_q;
      loop_d    = loop_q;
      wrap_d    = wrap_q;

      if (bus.start) begin
         // start wins over a same-cycle advance edge in every state
         state_d  = ST_LOAD;
         addr_d   = ADDR_ZERO;
         lfsr_d   = LFSR_SEED;
         notes_d  = 16'h0000;
         done_d   = 1'b0;
         random_d = bus.random_mode;
         loop_d   = bus.loop;
         wrap_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_LOAD: begin
               if (random_q) begin
                  // a zero pattern would be an invisible note; force lane 0
                  lfsr_d  = lfsr_next_s;
                  cmd_d   = (lfsr_next_s[3:0] == REST) ? LANE0_RED : lfsr_next_s[3:0];
                  index_d = addr_q;
                  valid_d = 1'b1;
                  state_d = ST_READY;
               end else if (rom_data_s[END_BIT] || wrap_q) begin
                  // wrap_q: we ran past the last address, which acts as END
                  wrap_d = 1'b0;
                  if (loop_q) begin
                     addr_d  = ADDR_ZERO;
                     state_d = ST_LOAD;
                  end else begin
                     cmd_d   = REST;
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end else begin
                  cmd_d   = rom_data_s[3:0];
                  index_d = addr_q;
                  valid_d = 1'b1;
                  state_d = ST_READY;
               end
            end
            ST_READY: begin
               if (adv_edge_s) begin
                  notes_d = (notes_q == 16'hFFFF) ? notes_q : notes_q + 16'h0001;
                  addr_d  = index_q + ADDR_ONE;
                  wrap_d  = ~random_q & (index_q == ADDR_LAST);
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_READY;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset forces all outputs to their idle values.
   always_ff @(posedge CLOCK_25 or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= ADDR_ZERO;
         lfsr_q    <= LFSR_SEED;
         cmd_q     <= REST;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         index_q   <= ADDR_ZERO;
         notes_q   <= 16'h0000;
         advance_q <= 1'b0;
         random_q  <= 1'b0;
         loop_q    <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         lfsr_q    <= lfsr_d;
         cmd_q     <= cmd_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         index_q   <= index_d;
         notes_q   <= notes_d;
         advance_q <= advance_d;
         random_q  <= random_d;
         loop_q    <= loop_d;
         wrap_q    <= wrap_d;
      end
   end

   assign bus.command_out  = cmd_q;
   assign bus.valid        = valid_q;
   assign bus.song_done    = done_q;
   assign bus.song_index   = index_q;
   assign bus.notes_played = notes_q;

endmodule
